reorder_buffer: RTL and testbench

- Circular in-order reorder buffer between decoder/issue and the register file.
- Allocates a rename tag per decoded instruction and captures results from the common data bus (CDB).
- Commits in program order to the register file; commit writes carry the tag so the regfile clears its rename mapping only when that mapping is still current.
- On commit of a mispredicted branch, raises the global flush and the redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 33 +++
 rtl/reorder_buffer_rob_tag_ptr.sv | 26 ++
 rtl/reorder_buffer.sv | 156 +++++++++++++++
 tb/tb_reorder_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: tag width, depth and entry layout.
// Tag 0 is reserved as "no tag / value lives in the regfile".
package reorder_buffer_pkg;

  localparam int ROB_ID_W  = 4;
  localparam int ROB_RANGE = 1 << ROB_ID_W;
  localparam int DEPTH     = ROB_RANGE - 1;
  localparam int REG_ID_W  = 5;

  localparam logic [ROB_ID_W-1:0] NO_TAG = 4'd0;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic                dest;
    logic                is_branch;
    logic                pred_taken;
    logic                mispredict;
    logic [REG_ID_W-1:0] reg_id;
    logic [31:0]         data;
    logic [31:0]         target;
  } rob_entry_t;

  // Wrap from DEPTH straight back to 1 so tag 0 is never handed out.
  function automatic logic [ROB_ID_W-1:0] next_tag(input logic [ROB_ID_W-1:0] tag);
    if (tag == ROB_ID_W'(DEPTH)) begin
      return ROB_ID_W'(1);
    end else begin
      return tag + ROB_ID_W'(1);
    end
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_tag_ptr.sv
// Circular tag pointer for the reorder buffer; counts 1..DEPTH and wraps past 0.
// clr returns the pointer to tag 1 (used on flush).
module rob_tag_ptr
  import reorder_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  output logic [ROB_ID_W-1:0] tag
);

  // Pointer register: reset/clear to the first valid tag, otherwise step on inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= ROB_ID_W'(1);
    end else if (clr) begin
      tag <= ROB_ID_W'(1);
    end else if (inc) begin
      tag <= next_tag(tag);
    end else begin
      tag <= tag;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: tag allocation, CDB capture, in-order commit and branch flush.
// Optional ROB_CDB_BYPASS_EN forwards a same-cycle CDB broadcast to the operand queries.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                from_decoder_valid,
  input  logic                from_decoder_has_dest,
  input  logic [REG_ID_W-1:0] from_decoder_reg_id,
  input  logic                from_decoder_is_branch,
  input  logic                from_decoder_pred_taken,
  input  logic                from_decoder_ready,
  input  logic [31:0]         from_decoder_data,
  output logic                to_decoder_full,
  output logic [ROB_ID_W-1:0] to_decoder_rob_id,
  input  logic [ROB_ID_W-1:0] query1_rob_id,
  input  logic [ROB_ID_W-1:0] query2_rob_id,
  output logic                query1_ready,
  output logic                query2_ready,
  output logic [31:0]         query1_data,
  output logic [31:0]         query2_data,
  input  logic                cdb_valid,
  input  logic [ROB_ID_W-1:0] cdb_rob_id,
  input  logic [31:0]         cdb_data,
  input  logic                cdb_taken,
  input  logic [31:0]         cdb_target,
  output logic                to_regfile_write_enabled,
  output logic [REG_ID_W-1:0] to_regfile_reg_id,
  output logic [31:0]         to_regfile_data,
  output logic [ROB_ID_W-1:0] to_regfile_rob_id,
  output logic                flush_output,
  output logic [31:0]         flush_pc
);

  rob_entry_t          entries [ROB_RANGE];
  logic [ROB_ID_W-1:0] head;
  logic [ROB_ID_W-1:0] tail;
  logic [ROB_ID_W-1:0] count_r;
  logic                alloc_s;
  logic                commit_s;
  logic                q1_ready_s;
  logic                q2_ready_s;
  logic [31:0]         q1_data_s;
  logic [31:0]         q2_data_s;

  assign to_decoder_full   = (count_r == ROB_ID_W'(DEPTH));
  assign to_decoder_rob_id = tail;
  assign alloc_s  = from_decoder_valid && !to_decoder_full && !flush_output;
  assign commit_s = entries[head].busy && entries[head].done && !flush_output;

  rob_tag_ptr u_head (
    .clk   (clk_in),
    .rst_n (rst_in),
    .clr   (flush_output),
    .inc   (commit_s),
    .tag   (head)
  );

  rob_tag_ptr u_tail (
    .clk   (clk_in),
    .rst_n (rst_in),
    .clr   (flush_output),
    .inc   (alloc_s),
    .tag   (tail)
  );

  // Occupancy: +1 on allocate, -1 on commit, unchanged when both happen.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count_r <= ROB_ID_W'(0);
    end else if (flush_output) begin
      count_r <= ROB_ID_W'(0);
    end else if (alloc_s && !commit_s) begin
      count_r <= count_r + ROB_ID_W'(1);
    end else if (commit_s && !alloc_s) begin
      count_r <= count_r - ROB_ID_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage; commit clears the head after any same-cycle CDB write to it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_RANGE; i++) entries[i] <= '0;
    end else if (flush_output) begin
      for (int i = 0; i < ROB_RANGE; i++) entries[i] <= '0;
    end else begin
      if (cdb_valid && entries[cdb_rob_id].busy) begin
        entries[cdb_rob_id].done       <= 1'b1;
        entries[cdb_rob_id].data       <= cdb_data;
        entries[cdb_rob_id].target     <= cdb_target;
        entries[cdb_rob_id].mispredict <= entries[cdb_rob_id].is_branch &&
                                          (cdb_taken != entries[cdb_rob_id].pred_taken);
      end
      if (commit_s) begin
        entries[head] <= '0;
      end
      if (alloc_s) begin
        entries[tail] <= '{busy:       1'b1,
                           done:       from_decoder_ready,
                           dest:       from_decoder_has_dest && (from_decoder_reg_id != 5'd0),
                           is_branch:  from_decoder_is_branch,
                           pred_taken: from_decoder_pred_taken,
                           mispredict: 1'b0,
                           reg_id:     from_decoder_reg_id,
                           data:       from_decoder_data,
                           target:     32'd0};
      end
    end
  end

  // Commit and flush pulses, registered one cycle after the commit decision.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      to_regfile_write_enabled <= 1'b0;
      to_regfile_reg_id        <= 5'd0;
      to_regfile_data          <= 32'd0;
      to_regfile_rob_id        <= ROB_ID_W'(0);
      flush_output             <= 1'b0;
      flush_pc                 <= 32'd0;
    end else begin
      to_regfile_write_enabled <= commit_s && entries[head].dest;
      to_regfile_reg_id        <= (commit_s && entries[head].dest) ? entries[head].reg_id : 5'd0;
      to_regfile_data          <= (commit_s && entries[head].dest) ? entries[head].data : 32'd0;
      to_regfile_rob_id        <= (commit_s && entries[head].dest) ? head : ROB_ID_W'(0);
      flush_output             <= commit_s && entries[head].mispredict;
      flush_pc                 <= (commit_s && entries[head].mispredict) ? entries[head].target : 32'd0;
    end
  end

  assign q1_ready_s = (query1_rob_id == NO_TAG) ||
                      (entries[query1_rob_id].busy && entries[query1_rob_id].done);
  assign q2_ready_s = (query2_rob_id == NO_TAG) ||
                      (entries[query2_rob_id].busy && entries[query2_rob_id].done);
  assign q1_data_s  = (query1_rob_id == NO_TAG) ? 32'd0 : entries[query1_rob_id].data;
  assign q2_data_s  = (query2_rob_id == NO_TAG) ? 32'd0 : entries[query2_rob_id].data;

`ifdef ROB_CDB_BYPASS_EN
  logic hit1_s;
  logic hit2_s;
  assign hit1_s       = cdb_valid && (cdb_rob_id != NO_TAG) && (cdb_rob_id == query1_rob_id);
  assign hit2_s       = cdb_valid && (cdb_rob_id != NO_TAG) && (cdb_rob_id == query2_rob_id);
  assign query1_ready = hit1_s ? 1'b1 : q1_ready_s;
  assign query2_ready = hit2_s ? 1'b1 : q2_ready_s;
  assign query1_data  = hit1_s ? cdb_data : q1_data_s;
  assign query2_data  = hit2_s ? cdb_data : q2_data_s;
`else
  assign query1_ready = q1_ready_s;
  assign query2_ready = q2_ready_s;
  assign query1_data  = q1_data_s;
  assign query2_data  = q2_data_s;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// all compared every cycle against a queue-based program-order model.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        from_decoder_valid = 1'b0;
  logic        from_decoder_has_dest = 1'b0;
  logic [4:0]  from_decoder_reg_id = 5'd0;
  logic        from_decoder_is_branch = 1'b0;
  logic        from_decoder_pred_taken = 1'b0;
  logic        from_decoder_ready = 1'b0;
  logic [31:0] from_decoder_data = 32'd0;
  logic        to_decoder_full;
  logic [3:0]  to_decoder_rob_id;
  logic [3:0]  query1_rob_id = 4'd0;
  logic [3:0]  query2_rob_id = 4'd0;
  logic        query1_ready, query2_ready;
  logic [31:0] query1_data, query2_data;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_rob_id = 4'd0;
  logic [31:0] cdb_data = 32'd0;
  logic        cdb_taken = 1'b0;
  logic [31:0] cdb_target = 32'd0;
  logic        to_regfile_write_enabled;
  logic [4:0]  to_regfile_reg_id;
  logic [31:0] to_regfile_data;
  logic [3:0]  to_regfile_rob_id;
  logic        flush_output;
  logic [31:0] flush_pc;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .from_decoder_valid(from_decoder_valid), .from_decoder_has_dest(from_decoder_has_dest),
    .from_decoder_reg_id(from_decoder_reg_id), .from_decoder_is_branch(from_decoder_is_branch),
    .from_decoder_pred_taken(from_decoder_pred_taken), .from_decoder_ready(from_decoder_ready),
    .from_decoder_data(from_decoder_data), .to_decoder_full(to_decoder_full),
    .to_decoder_rob_id(to_decoder_rob_id),
    .query1_rob_id(query1_rob_id), .query2_rob_id(query2_rob_id),
    .query1_ready(query1_ready), .query2_ready(query2_ready),
    .query1_data(query1_data), .query2_data(query2_data),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .to_regfile_write_enabled(to_regfile_write_enabled), .to_regfile_reg_id(to_regfile_reg_id),
    .to_regfile_data(to_regfile_data), .to_regfile_rob_id(to_regfile_rob_id),
    .flush_output(flush_output), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  // Program-order model: one queue element per in-flight instruction.
  typedef struct {
    int          tag;
    bit          dest;
    int          rg;
    bit          br;
    bit          pred;
    bit          done;
    logic [31:0] data;
    bit          mis;
    logic [31:0] tgt;
  } ment_t;

  ment_t       q[$];
  int          m_tail;
  bit          m_we, m_flush;
  int          m_reg, m_wtag;
  logic [31:0] m_wdata, m_fpc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pin_q1 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nt(input int t);
    return (t == 15) ? 1 : t + 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_tail = 1; m_we = 0; m_flush = 0; m_reg = 0; m_wtag = 0; m_wdata = 32'd0; m_fpc = 32'd0;
  endtask

  task automatic exp_query(input int id, output bit r, output logic [31:0] d);
    r = 0; d = 32'd0;
    if (id == 0) begin
      r = 1;
    end else begin
      foreach (q[i]) if (q[i].tag == id) begin r = q[i].done; d = q[i].data; end
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_valid && int'(cdb_rob_id) == id) begin r = 1; d = cdb_data; end
`endif
    end
  endtask

  task automatic model_step();
    ment_t h;
    ment_t n;
    bit    full;
    bit    do_commit;
    if (m_flush) begin
      model_reset();
    end else begin
      full = (q.size() == 15);
      do_commit = (q.size() > 0) && q[0].done;
      m_we = 0; m_reg = 0; m_wtag = 0; m_wdata = 32'd0; m_flush = 0; m_fpc = 32'd0;
      if (do_commit) begin
        h = q.pop_front();
        if (h.dest) begin m_we = 1; m_reg = h.rg; m_wdata = h.data; m_wtag = h.tag; end
        if (h.mis) begin m_flush = 1; m_fpc = h.tgt; end
      end
      if (cdb_valid) begin
        foreach (q[i]) if (q[i].tag == int'(cdb_rob_id)) begin
          q[i].done = 1; q[i].data = cdb_data; q[i].tgt = cdb_target;
          q[i].mis  = q[i].br && (cdb_taken != q[i].pred);
        end
      end
      if (from_decoder_valid && !full) begin
        n.tag = m_tail; n.dest = from_decoder_has_dest && (from_decoder_reg_id != 5'd0);
        n.rg = int'(from_decoder_reg_id); n.br = from_decoder_is_branch;
        n.pred = from_decoder_pred_taken; n.done = from_decoder_ready;
        n.data = from_decoder_data; n.mis = 0; n.tgt = 32'd0;
        q.push_back(n);
        m_tail = nt(m_tail);
      end
    end
  endtask

  task automatic clear_inputs();
    from_decoder_valid = 1'b0; from_decoder_has_dest = 1'b0; from_decoder_reg_id = 5'd0;
    from_decoder_is_branch = 1'b0; from_decoder_pred_taken = 1'b0; from_decoder_ready = 1'b0;
    from_decoder_data = 32'd0; cdb_valid = 1'b0; cdb_rob_id = 4'd0; cdb_data = 32'd0;
    cdb_taken = 1'b0; cdb_target = 32'd0;
  endtask

  // Called just after a falling edge with inputs set; checks, advances model, clocks once.
  task automatic step();
    bit          r;
    logic [31:0] d;
    query1_rob_id = (pin_q1 != 0) ? 4'(pin_q1) : 4'($urandom_range(0, 15));
    query2_rob_id = 4'($urandom_range(0, 15));
    #1;
    check_eq("full", 32'(to_decoder_full), 32'(q.size() == 15));
    check_eq("rob_id", 32'(to_decoder_rob_id), 32'(m_tail));
    check_eq("rf_we", 32'(to_regfile_write_enabled), 32'(m_we));
    check_eq("rf_reg", 32'(to_regfile_reg_id), 32'(m_reg));
    check_eq("rf_data", to_regfile_data, m_wdata);
    check_eq("rf_tag", 32'(to_regfile_rob_id), 32'(m_wtag));
    check_eq("flush", 32'(flush_output), 32'(m_flush));
    check_eq("flush_pc", flush_pc, m_fpc);
    exp_query(int'(query1_rob_id), r, d);
    check_eq("q1_ready", 32'(query1_ready), 32'(r));
    check_eq("q1_data", query1_data, d);
    exp_query(int'(query2_rob_id), r, d);
    check_eq("q2_ready", 32'(query2_ready), 32'(r));
    check_eq("q2_data", query2_data, d);
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    clear_inputs();
  endtask

  task automatic alloc(input bit hd, input int rg, input bit br, input bit pr, input bit rdy,
                       input logic [31:0] dat);
    from_decoder_valid = 1'b1; from_decoder_has_dest = hd; from_decoder_reg_id = 5'(rg);
    from_decoder_is_branch = br; from_decoder_pred_taken = pr; from_decoder_ready = rdy;
    from_decoder_data = dat;
  endtask

  task automatic cdb(input int tag, input logic [31:0] dat, input bit tk, input logic [31:0] tg);
    cdb_valid = 1'b1; cdb_rob_id = 4'(tag); cdb_data = dat; cdb_taken = tk; cdb_target = tg;
  endtask

  initial begin
    int t0;
    model_reset();
    repeat (2) @(negedge clk_in);
    #1;
    check_eq("rst_full", 32'(to_decoder_full), 32'd0);
    check_eq("rst_rob_id", 32'(to_decoder_rob_id), 32'd1);
    check_eq("rst_we", 32'(to_regfile_write_enabled), 32'd0);
    check_eq("rst_flush", 32'(flush_output), 32'd0);
    check_eq("rst_q1_ready", 32'(query1_ready), 32'd1);
    check_eq("rst_q1_data", query1_data, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Basic allocate / complete / commit.
    alloc(1, 5, 0, 0, 0, 32'd0); step();
    cdb(1, 32'hDEADBEEF, 0, 32'd0); step();
    pin_q1 = 1; step(); pin_q1 = 0;
    step(); step();

    // Fill to full, drop a 16th, then drain.
    for (int i = 0; i < 15; i++) begin alloc(1, i + 1, 0, 0, 0, 32'(i)); step(); end
    alloc(1, 9, 0, 0, 0, 32'h55); step();
    cdb(1, 32'h1111, 0, 32'd0); step();
    step(); step();
    for (int i = 2; i <= 15; i++) begin cdb(i, 32'(i * 3), 0, 32'd0); step(); end
    repeat (3) step();

    // Out-of-order completion.
    t0 = m_tail;
    for (int i = 0; i < 3; i++) begin alloc(1, 10 + i, 0, 0, 0, 32'd0); step(); end
    cdb(nt(nt(t0)), 32'hC3, 0, 32'd0); step();
    cdb(nt(t0), 32'hC2, 0, 32'd0); step();
    cdb(t0, 32'hC1, 0, 32'd0); step();
    repeat (4) step();

    // Mispredicted branch behind an older instruction, with a younger one in flight.
    t0 = m_tail;
    alloc(1, 3, 0, 0, 0, 32'd0); step();
    alloc(0, 0, 1, 0, 0, 32'd0); step();
    alloc(1, 4, 0, 0, 1, 32'h77); step();
    cdb(nt(t0), 32'd0, 1, 32'h100); step();
    cdb(t0, 32'hA5, 0, 32'd0); step();
    repeat (4) step();

    // Back-to-back allocate/commit pairs across the tag wrap.
    for (int i = 0; i < 20; i++) begin
      check_eq("tag_nonzero", 32'(to_decoder_rob_id != 4'd0), 32'd1);
      alloc(1, (i % 31) + 1, 0, 0, 1, 32'(i + 100)); step();
    end
    repeat (3) step();

    // Asynchronous reset with a commit pulse on the outputs.
    alloc(1, 7, 0, 0, 1, 32'hBEEF); step();
    alloc(1, 8, 0, 0, 1, 32'hCAFE); step();
    check_eq("pre_rst_we", 32'(to_regfile_write_enabled), 32'd1);
    rst_in = 1'b0;
    #1;
    check_eq("arst_we", 32'(to_regfile_write_enabled), 32'd0);
    check_eq("arst_data", to_regfile_data, 32'd0);
    check_eq("arst_flush", 32'(flush_output), 32'd0);
    check_eq("arst_rob_id", 32'(to_decoder_rob_id), 32'd1);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    step();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) != 0)
        alloc(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom);
      if ($urandom_range(0, 1) != 0) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          cdb(q[$urandom_range(0, q.size() - 1)].tag, $urandom, 1'($urandom_range(0, 1)), $urandom);
        else
          cdb($urandom_range(1, 15), $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
